// File: rtl/fifo_tape_player.sv
// Re-encodes bytes popped from the receiver FIFO as ROM-format tape pulses
// (pilot, sync1, sync2, data MSB first); FIFO silence closes the block.
module fifo_tape_player #(
  parameter int CLOCK          = 56842105,
  parameter int PILOT_HALF     = (CLOCK / 1000) * 2168 / 3500,
  parameter int SYNC1_HALF     = (CLOCK / 1000) * 667 / 3500,
  parameter int SYNC2_HALF     = (CLOCK / 1000) * 735 / 3500,
  parameter int ZERO_HALF      = (CLOCK / 1000) * 855 / 3500,
  parameter int ONE_HALF       = (CLOCK / 1000) * 1710 / 3500,
  parameter int PILOT_HDR      = 8063,
  parameter int PILOT_DAT      = 3223,
  parameter int END_GAP_CYCLES = CLOCK / 10
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_data,
  output logic       o_fifo_read_req,
  output logic       o_tape_in,
  output logic       o_busy,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PILOT = 3'd2,
    S_SYNC1 = 3'd3,
    S_SYNC2 = 3'd4,
    S_DATA  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  localparam logic [15:0] L_PILOT    = 16'(PILOT_HALF);
  localparam logic [15:0] L_SYNC1    = 16'(SYNC1_HALF);
  localparam logic [15:0] L_SYNC2    = 16'(SYNC2_HALF);
  localparam logic [15:0] L_ZERO     = 16'(ZERO_HALF);
  localparam logic [15:0] L_ONE      = 16'(ONE_HALF);
  localparam logic [15:0] L_HDR_M1   = 16'(PILOT_HDR - 1);
  localparam logic [15:0] L_DAT_M1   = 16'(PILOT_DAT - 1);
  localparam logic [22:0] L_GAP_LAST = 23'(END_GAP_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_left;
  logic [22:0] r_gap;
  logic [2:0]  r_bit;
  logic        r_second;
  logic [7:0]  r_byte;
  logic [7:0]  r_shadow;
  logic        r_shadow_valid;
  logic        r_rd_d;
  logic        r_tape;
  logic        r_busy;

  logic [15:0] w_half;
  logic        w_half_end;
  logic        w_prefetch_slot;
  logic        w_pop;

  always_comb begin
    w_half = L_PILOT;
    unique case (r_state)
      S_SYNC1: w_half = L_SYNC1;
      S_SYNC2: w_half = L_SYNC2;
      S_DATA:  w_half = r_byte[r_bit] ? L_ONE : L_ZERO;
      default: w_half = L_PILOT;
    endcase
  end

  assign w_half_end      = (r_cnt == w_half - 16'd1);
  assign w_prefetch_slot = (r_state == S_DATA) && (r_bit == 3'd0) && r_second && (r_cnt == 16'd0);

  // Pop strobe: one cycle, only while the FIFO reports data; q is captured
  // on the following cycle (r_rd_d marks that capture cycle).
  assign w_pop = !i_reset && i_enable && !i_fifo_empty &&
                 ((r_state == S_IDLE) || w_prefetch_slot || ((r_state == S_WAIT) && !r_rd_d));

  always_ff @(posedge i_clock) begin
    if (i_reset || !i_enable) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_left         <= '0;
      r_gap          <= '0;
      r_bit          <= '0;
      r_second       <= 1'b0;
      r_byte         <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_rd_d         <= 1'b0;
      r_tape         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_rd_d <= w_pop;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_byte  <= i_fifo_data;
          r_left  <= i_fifo_data[7] ? L_DAT_M1 : L_HDR_M1;
          r_busy  <= 1'b1;
          r_tape  <= ~r_tape;
          r_cnt   <= '0;
          r_state <= S_PILOT;
        end
        S_PILOT: begin
          if (w_half_end) begin
            r_tape <= ~r_tape;
            r_cnt  <= '0;
            if (r_left != 16'd0) r_left <= r_left - 16'd1;
            else                 r_state <= S_SYNC1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SYNC1: begin
          if (w_half_end) begin
            r_tape  <= ~r_tape;
            r_cnt   <= '0;
            r_state <= S_SYNC2;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SYNC2: begin
          if (w_half_end) begin
            r_tape   <= ~r_tape;
            r_cnt    <= '0;
            r_bit    <= 3'd7;
            r_second <= 1'b0;
            r_state  <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_rd_d) begin
            r_shadow       <= i_fifo_data;
            r_shadow_valid <= 1'b1;
          end
          if (w_half_end) begin
            r_cnt <= '0;
            if (!r_second) begin
              r_second <= 1'b1;
              r_tape   <= ~r_tape;
            end else if (r_bit != 3'd0) begin
              r_bit    <= r_bit - 3'd1;
              r_second <= 1'b0;
              r_tape   <= ~r_tape;
            end else if (r_shadow_valid) begin
              // Prefetched byte follows with no idle cycles.
              r_byte         <= r_shadow;
              r_shadow_valid <= 1'b0;
              r_bit          <= 3'd7;
              r_second       <= 1'b0;
              r_tape         <= ~r_tape;
            end else begin
              r_gap   <= '0;
              r_state <= S_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT: begin
          if (r_rd_d) begin
            r_byte   <= i_fifo_data;
            r_bit    <= 3'd7;
            r_second <= 1'b0;
            r_tape   <= ~r_tape;
            r_cnt    <= '0;
            r_state  <= S_DATA;
          end else if (!w_pop) begin
            if (r_gap == L_GAP_LAST) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_gap <= r_gap + 23'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_fifo_read_req = w_pop;
  assign o_tape_in       = r_tape;
  assign o_busy          = r_busy;
  assign o_state         = r_state;

endmodule
